irq_encoder: RTL
================

IRQ_ENCODER -- requirements
Module: irq_encoder

Interface
REQ-001 clk  input  1  system clock; all state changes on rising edge.
REQ-002 rst_n  input  1  asynchronous, active-low reset.
REQ-003 req  input  16  request lines, one per source; index i = source i.
REQ-004 mask  input  16  enable per source; 1 = source i may be granted.
REQ-005 ack  input  1  consumer accepts current code; honoured only while valid=1.
REQ-006 valid  output  1  code holds a granted source index.
REQ-007 code  output  4  binary index of granted source; inverse of the 4-to-16 one-hot decode (bit i -> 4'di).
REQ-008 pending  output  16  latched, not-yet-acknowledged request events.
REQ-009 lost  output  1  sticky flag; a request event arrived for a source already pending.

Function
REQ-010 Per-bit registered copy req_q of req; event on source i when req[i]=1 and req_q[i]=0 at a rising edge.
REQ-011 Event on source i sets pending[i] at that same edge.
REQ-012 Event on source i while pending[i]=1 sets lost=1; pending[i] stays 1.
REQ-013 Eligible vector = pending & mask; highest set index has priority (15 highest, 0 lowest).
REQ-014 FSM states: IDLE, PRESENT.
REQ-015 IDLE: valid=0; eligible nonzero at an edge -> load code with priority index, go PRESENT (valid=1 after that edge).
REQ-016 IDLE: eligible zero -> remain IDLE, code holds last value.
REQ-017 PRESENT: valid=1, code frozen; later higher-priority events or mask changes do not alter code or drop valid.
REQ-018 PRESENT with ack=1 at an edge -> clear pending[code], go IDLE (valid=0 after that edge).
REQ-019 Same edge sets and clears pending[code] (new event on granted source coincident with ack) -> set wins, pending[code]=1, lost unchanged.
REQ-020 ack in IDLE ignored; no state or pending change.
REQ-021 Latency: req rising seen at edge k -> pending set at edge k -> valid=1 after edge k+1 (if masked-in and FSM idle).
REQ-022 Back-to-back grants separated by at least one valid=0 cycle (IDLE re-evaluates after every ack).
REQ-023 Masked-out pending bits retained indefinitely; become eligible when mask bit set.
REQ-024 Level-held req produces exactly one event; req must return to 0 for a further event.

Reset
REQ-025 rst_n=0 asynchronously forces: state IDLE, valid=0, code=4'd0, pending=16'h0000, req_q=16'h0000, lost=0.
REQ-026 lost cleared only by reset.
REQ-027 Reset asserted mid-PRESENT discards grant and all pending; req held high across reset release produces one event at the first edge after release.

Verification
REQ-028 mask=16'hFFFF, req[5] pulse 0->1 -> pending=16'h0020 same edge; valid=1, code=4'd5 one edge later; ack=1 -> valid=0, pending=16'h0000.
REQ-029 req=16'h8011 rising together, mask=16'hFFFF -> grants in order code 15, 4, 0, each acked, valid=0 for at least one cycle between grants.
REQ-030 mask=16'h00FF, req[12] and req[3] events -> code=4'd3 granted; after ack, pending=16'h1000, valid stays 0; set mask[12]=1 -> code=4'd12.
REQ-031 While PRESENT code=4'd2, req[9] event -> code stays 2, pending=16'h0204; ack -> next grant code=4'd9.
REQ-032 Source 7 pending, second req[7] event before ack -> lost=1; ack coincident with new req[7] event -> pending[7] remains 1, regranted code=4'd7.
REQ-033 rst_n driven low asynchronously mid-PRESENT (code=4'd6) -> valid=0, code=4'd0, pending=0, lost=0 before next clock edge.

Source files
------------

// File: rtl/irq_encoder_if.sv
// Bundle of the request/grant signals between an interrupt consumer and
// irq_encoder. The consumer (master) drives req, mask and ack. The encoder
// (slave) returns the grant (valid/code) and the pending/lost status.
interface irq_encoder_if;
  logic [15:0] req;
  logic [15:0] mask;
  logic        ack;
  logic        valid;
  logic [3:0]  code;
  logic [15:0] pending;
  logic        lost;

  modport master (
    output req,
    output mask,
    output ack,
    input  valid,
    input  code,
    input  pending,
    input  lost
  );

  modport slave (
    input  req,
    input  mask,
    input  ack,
    output valid,
    output code,
    output pending,
    output lost
  );
endinterface

// File: rtl/irq_encoder.sv
// Edge-triggered 16-source interrupt priority encoder.
// Each rising request edge latches a pending bit. The highest-index pending
// source that is masked in is presented as a binary code, and that code is
// held until the consumer acknowledges it. A sticky 'lost' flag records any
// request edge that arrives for a source which is already pending.
module irq_encoder (
  input  logic           clk,
  input  logic           rst_n,
  irq_encoder_if.slave   bus
);

  typedef enum logic [0:0] {
    ST_IDLE    = 1'b0,
    ST_PRESENT = 1'b1
  } state_e;

  // Highest set bit index of a 16-bit vector. Returns 0 for an empty vector.
  // Callers only use the result when the vector is nonzero.
  function automatic logic [3:0] prio_index(input logic [15:0] vec);
    logic [3:0] idx;
    idx = 4'd0;
    for (int i = 0; i < 16; i++) begin
      if (vec[i]) begin
        idx = 4'(i);
      end else begin
        idx = idx;
      end
    end
    return idx;
  endfunction

  // 4-to-16 one-hot decode. This is the inverse of prio_index for a single set bit.
  function automatic logic [15:0] onehot16(input logic [3:0] idx);
    return 16'h0001 << idx;
  endfunction

  state_e      state_q, state_d;
  logic [15:0] req_q;
  logic [15:0] pending_q, pending_d;
  logic [3:0]  code_q, code_d;
  logic        lost_q, lost_d;

  logic [15:0] event_s;
  logic [15:0] clr_s;
  logic [15:0] eligible_s;
  logic        ack_take_s;

  // Event detection and pending/lost bookkeeping. When a new event and an ack
  // land on the granted source in the same cycle, the set takes precedence.
  // That event re-arms the source, and the flag does not count it as lost.
  always_comb begin
    event_s    = bus.req & ~req_q;
    ack_take_s = (state_q == ST_PRESENT) && bus.ack;
    if (ack_take_s) begin
      clr_s = onehot16(code_q);
    end else begin
      clr_s = 16'h0000;
    end
    pending_d  = (pending_q & ~clr_s) | event_s;
    lost_d     = lost_q | (|(event_s & pending_q & ~clr_s));
    eligible_s = pending_q & bus.mask;
  end

  // Grant FSM next state. The code is loaded only when leaving IDLE and stays
  // frozen while the grant is presented.
  always_comb begin
    state_d = state_q;
    code_d  = code_q;
    case (state_q)
      ST_IDLE: begin
        if (eligible_s != 16'h0000) begin
          code_d  = prio_index(eligible_s);
          state_d = ST_PRESENT;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_PRESENT: begin
        if (bus.ack) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_PRESENT;
        end
      end
      default: begin
        state_d = ST_IDLE;
        code_d  = 4'd0;
      end
    endcase
  end

  // State and status registers. An asynchronous reset drops the grant and all history.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      req_q     <= 16'h0000;
      pending_q <= 16'h0000;
      code_q    <= 4'd0;
      lost_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      req_q     <= bus.req;
      pending_q <= pending_d;
      code_q    <= code_d;
      lost_q    <= lost_d;
    end
  end

  assign bus.valid   = (state_q == ST_PRESENT);
  assign bus.code    = code_q;
  assign bus.pending = pending_q;
  assign bus.lost    = lost_q;

endmodule
